// File: rtl/stim_gen_arqui_if.sv
// ---------------------------------------------------------------------------
// stim_gen_arqui_if
// Bundles the streaming signals between the traffic generator and the arqui
// datapath it exercises.
//
// Signals:
//   push_main        generator -> arqui   registered push strobe, main FIFO
//   data_out         generator -> arqui   word pushed when push_main=1
//   pop              generator -> arqui   per-channel pop strobes (D FIFOs)
//   fifo_pause_main  arqui -> generator   main FIFO backpressure
//   fifo_empty       arqui -> generator   per-channel D FIFO empty flags
//   error_in         arqui -> generator   error flags, any bit set freezes
//
// Modports:
//   master  the generator side (drives push/data/pop)
//   slave   the datapath side (drives pause/empty/error)
// ---------------------------------------------------------------------------
interface stim_gen_arqui_if #(
  parameter int DATA_W = 6,
  parameter int NUM_CH = 2,
  parameter int ERR_W  = 5
);

  logic              push_main;
  logic [DATA_W-1:0] data_out;
  logic [NUM_CH-1:0] pop;
  logic              fifo_pause_main;
  logic [NUM_CH-1:0] fifo_empty;
  logic [ERR_W-1:0]  error_in;

  modport master (
    output push_main,
    output data_out,
    output pop,
    input  fifo_pause_main,
    input  fifo_empty,
    input  error_in
  );

  modport slave (
    input  push_main,
    input  data_out,
    input  pop,
    output fifo_pause_main,
    output fifo_empty,
    output error_in
  );

endinterface

// File: rtl/stim_gen_arqui.sv
// ---------------------------------------------------------------------------
// stim_gen_arqui
// Traffic generator and drain engine for the arqui datapath. A start pulse
// latches the run configuration, programs the FIFO thresholds, pulses init,
// waits CFG_WAIT cycles and then pushes num_bursts bursts of incrementing
// words into the main FIFO, separated by gap_len idle cycles. Every non-empty
// output channel is popped in parallel, and push/pop totals are kept so the
// two sides of the datapath can be compared.
//
// Ports:
//   clk, reset_L        clock (rising edge) and synchronous active-low reset
//   start               begin a sequence (honoured in IDLE or DONE only)
//   burst_len           words per burst
//   num_bursts          number of bursts
//   gap_len             idle cycles between bursts
//   seed, seed_step     first word of burst 0 / per-burst start increment
//   drain_en            allows popping of the output channels
//   bus                 master side of stim_gen_arqui_if (push/data/pop out,
//                       pause/empty/error in)
//   init                one-cycle pulse while configuring
//   afMF..aeDF          almost-full / almost-empty thresholds
//   busy, done          sequence in progress / sequence finished
//   push_count          words pushed since the last start (saturating)
//   pop_count           pops issued since the last start (saturating)
// ---------------------------------------------------------------------------
module stim_gen_arqui #(
  parameter int DATA_W   = 6,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int BURST_W  = 4,
  parameter int ERR_W    = 5,
  parameter int CFG_WAIT = 2,
  parameter int MF_W     = 2,
  parameter int VC_W     = 4,
  parameter int DF_W     = 2,
  parameter int AF_MF    = 3,
  parameter int AE_MF    = 1,
  parameter int AF_VC    = 14,
  parameter int AE_VC    = 2,
  parameter int AF_DF    = 3,
  parameter int AE_DF    = 1
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     start,
  input  logic [CNT_W-1:0]         burst_len,
  input  logic [BURST_W-1:0]       num_bursts,
  input  logic [CNT_W-1:0]         gap_len,
  input  logic [DATA_W-1:0]        seed,
  input  logic [DATA_W-1:0]        seed_step,
  input  logic                     drain_en,
  stim_gen_arqui_if.master         bus,
  output logic                     init,
  output logic [MF_W-1:0]          afMF,
  output logic [MF_W-1:0]          aeMF,
  output logic [VC_W-1:0]          afVC,
  output logic [VC_W-1:0]          aeVC,
  output logic [DF_W-1:0]          afDF,
  output logic [DF_W-1:0]          aeDF,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W+BURST_W-1:0] push_count,
  output logic [CNT_W+BURST_W-1:0] pop_count
);

  localparam int CW = CNT_W + BURST_W;

  // WAIT lasts CFG_WAIT cycles; a value below 1 still costs one cycle.
  localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'((CFG_WAIT > 1) ? CFG_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0]   ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W:0]     ONE_CNTX  = (CNT_W + 1)'(1);
  localparam logic [BURST_W:0]   ONE_BX    = (BURST_W + 1)'(1);
  localparam logic [DATA_W-1:0]  ONE_D     = DATA_W'(1);
  localparam logic [CW-1:0]      ONE_W     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    burstLen_q, burstLen_d;
  logic [BURST_W-1:0]  numBursts_q, numBursts_d;
  logic [CNT_W-1:0]    gapLen_q, gapLen_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   step_q, step_d;
  logic [DATA_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic [BURST_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [CNT_W-1:0]    gapCnt_q, gapCnt_d;
  logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;
  logic                pushMain_q, pushMain_d;
  logic [DATA_W-1:0]   dataOut_q, dataOut_d;
  logic                init_q, init_d;
  logic [MF_W-1:0]     afMF_q, afMF_d, aeMF_q, aeMF_d;
  logic [VC_W-1:0]     afVC_q, afVC_d, aeVC_q, aeVC_d;
  logic [DF_W-1:0]     afDF_q, afDF_d, aeDF_q, aeDF_d;
  logic [CW-1:0]       pushCount_q, pushCount_d;
  logic [CW-1:0]       popCount_q, popCount_d;

  logic [NUM_CH-1:0]   popVec;
  logic [CW:0]         popSum;
  logic                errActive;
  logic                drainPhase;

  logic [CNT_W:0]      sentNext;
  logic [CNT_W:0]      gapNext;
  logic [BURST_W:0]    kNext;
  logic                lastWord;
  logic                gapOver;
  logic                moreBursts;

  // One-bit-wider sums so the comparisons cannot be fooled by wrap-around.
  assign sentNext   = {1'b0, sent_q} + ONE_CNTX;
  assign gapNext    = {1'b0, gapCnt_q} + ONE_CNTX;
  assign kNext      = {1'b0, k_q} + ONE_BX;
  assign lastWord   = sentNext >= {1'b0, burstLen_q};
  assign gapOver    = gapNext >= {1'b0, gapLen_q};
  assign moreBursts = kNext < {1'b0, numBursts_q};

  // State and datapath registers. Reset is sampled on the clock edge, so a
  // reset edge in the middle of a burst wins over the push of that edge.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q     <= S_IDLE;
      burstLen_q  <= '0;
      numBursts_q <= '0;
      gapLen_q    <= '0;
      seed_q      <= '0;
      step_q      <= '0;
      base_q      <= '0;
      cur_q       <= '0;
      k_q         <= '0;
      sent_q      <= '0;
      gapCnt_q    <= '0;
      waitCnt_q   <= '0;
      pushMain_q  <= 1'b0;
      dataOut_q   <= '0;
      init_q      <= 1'b0;
      afMF_q      <= '0;
      aeMF_q      <= '0;
      afVC_q      <= '0;
      aeVC_q      <= '0;
      afDF_q      <= '0;
      aeDF_q      <= '0;
      pushCount_q <= '0;
      popCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      burstLen_q  <= burstLen_d;
      numBursts_q <= numBursts_d;
      gapLen_q    <= gapLen_d;
      seed_q      <= seed_d;
      step_q      <= step_d;
      base_q      <= base_d;
      cur_q       <= cur_d;
      k_q         <= k_d;
      sent_q      <= sent_d;
      gapCnt_q    <= gapCnt_d;
      waitCnt_q   <= waitCnt_d;
      pushMain_q  <= pushMain_d;
      dataOut_q   <= dataOut_d;
      init_q      <= init_d;
      afMF_q      <= afMF_d;
      aeMF_q      <= aeMF_d;
      afVC_q      <= afVC_d;
      aeVC_q      <= aeVC_d;
      afDF_q      <= afDF_d;
      aeDF_q      <= aeDF_d;
      pushCount_q <= pushCount_d;
      popCount_q  <= popCount_d;
    end
  end

  // Next-state logic. Everything holds by default; push_main and init are
  // strobes that fall back to 0 unless this cycle asserts them. The pop
  // total accumulates in every state and is only overridden by a new start.
  always_comb begin
    state_d     = state_q;
    burstLen_d  = burstLen_q;
    numBursts_d = numBursts_q;
    gapLen_d    = gapLen_q;
    seed_d      = seed_q;
    step_d      = step_q;
    base_d      = base_q;
    cur_d       = cur_q;
    k_d         = k_q;
    sent_d      = sent_q;
    gapCnt_d    = gapCnt_q;
    waitCnt_d   = waitCnt_q;
    pushMain_d  = 1'b0;
    dataOut_d   = dataOut_q;
    init_d      = 1'b0;
    afMF_d      = afMF_q;
    aeMF_d      = aeMF_q;
    afVC_d      = afVC_q;
    aeVC_d      = aeVC_q;
    afDF_d      = afDF_q;
    aeDF_d      = aeDF_q;
    pushCount_d = pushCount_q;
    popCount_d  = popSum[CW] ? '1 : popSum[CW-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          burstLen_d  = burst_len;
          numBursts_d = num_bursts;
          gapLen_d    = gap_len;
          seed_d      = seed;
          step_d      = seed_step;
          pushCount_d = '0;
          popCount_d  = '0;
          init_d      = 1'b1;
          state_d     = S_CFG;
        end
      end

      S_CFG: begin
        afMF_d    = MF_W'(AF_MF);
        aeMF_d    = MF_W'(AE_MF);
        afVC_d    = VC_W'(AF_VC);
        aeVC_d    = VC_W'(AE_VC);
        afDF_d    = DF_W'(AF_DF);
        aeDF_d    = DF_W'(AE_DF);
        waitCnt_d = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (waitCnt_q >= WAIT_LAST) begin
          cur_d   = seed_q;
          base_d  = seed_q;
          k_d     = '0;
          sent_d  = '0;
          state_d = (numBursts_q == '0) ? S_DONE : S_RUN;
        end else begin
          waitCnt_d = waitCnt_q + ONE_CNT;
        end
      end

      // An error freezes the burst completely; an empty burst moves on
      // without pushing; pause only withholds the push.
      S_RUN: begin
        if (!errActive) begin
          if (burstLen_q == '0) begin
            gapCnt_d = '0;
            state_d  = moreBursts ? S_GAP : S_DONE;
          end else if (!bus.fifo_pause_main) begin
            pushMain_d = 1'b1;
            dataOut_d  = cur_q;
            cur_d      = cur_q + ONE_D;
            sent_d     = sentNext[CNT_W-1:0];
            if (pushCount_q != '1) begin
              pushCount_d = pushCount_q + ONE_W;
            end
            if (lastWord) begin
              gapCnt_d = '0;
              state_d  = moreBursts ? S_GAP : S_DONE;
            end
          end
        end
      end

      // GAP occupies max(gap_len,1) cycles, so push_main idles for exactly
      // gap_len cycles whenever gap_len is non-zero.
      S_GAP: begin
        if (gapOver) begin
          k_d     = kNext[BURST_W-1:0];
          base_d  = base_q + step_q;
          cur_d   = base_q + step_q;
          sent_d  = '0;
          state_d = S_RUN;
        end else begin
          gapCnt_d = gapNext[CNT_W-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. Pops are combinational so the drain reacts in the same
  // cycle the channel reports data; popSum feeds the saturating pop total.
  always_comb begin
    errActive  = |bus.error_in;
    drainPhase = (state_q != S_IDLE) && (state_q != S_CFG);
    popVec     = '0;
    if (drainPhase && drain_en && !errActive) begin
      popVec = ~bus.fifo_empty;
    end
    popSum = {1'b0, popCount_q};
    for (int i = 0; i < NUM_CH; i++) begin
      popSum = popSum + {{CW{1'b0}}, popVec[i]};
    end
    busy = (state_q == S_CFG) || (state_q == S_WAIT) ||
           (state_q == S_RUN) || (state_q == S_GAP);
    done = (state_q == S_DONE);
  end

  assign bus.push_main = pushMain_q;
  assign bus.data_out  = dataOut_q;
  assign bus.pop       = popVec;
  assign init          = init_q;
  assign afMF          = afMF_q;
  assign aeMF          = aeMF_q;
  assign afVC          = afVC_q;
  assign aeVC          = aeVC_q;
  assign afDF          = afDF_q;
  assign aeDF          = aeDF_q;
  assign push_count    = pushCount_q;
  assign pop_count     = popCount_q;

endmodule

// File: tb/tb_stim_gen_arqui.sv
// ---------------------------------------------------------------------------
// tb_stim_gen_arqui
// Directed testbench for stim_gen_arqui with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge, away from the active
// rising edge. Each scenario task drives its stimulus and checks inline.
// ---------------------------------------------------------------------------
module tb_stim_gen_arqui;

  localparam int DATA_W  = 6;
  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 8;
  localparam int BURST_W = 4;
  localparam int ERR_W   = 5;
  localparam int CW      = CNT_W + BURST_W;

  logic               clk = 1'b0;
  logic               reset_L;
  logic               start;
  logic [CNT_W-1:0]   burst_len;
  logic [BURST_W-1:0] num_bursts;
  logic [CNT_W-1:0]   gap_len;
  logic [DATA_W-1:0]  seed;
  logic [DATA_W-1:0]  seed_step;
  logic               drain_en;
  logic               init;
  logic [1:0]         afMF, aeMF;
  logic [3:0]         afVC, aeVC;
  logic [1:0]         afDF, aeDF;
  logic               busy;
  logic               done;
  logic [CW-1:0]      push_count;
  logic [CW-1:0]      pop_count;

  int checks = 0;
  int errors = 0;

  stim_gen_arqui_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ERR_W(ERR_W)) bus ();

  stim_gen_arqui dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .start      (start),
    .burst_len  (burst_len),
    .num_bursts (num_bursts),
    .gap_len    (gap_len),
    .seed       (seed),
    .seed_step  (seed_step),
    .drain_en   (drain_en),
    .bus        (bus),
    .init       (init),
    .afMF       (afMF),
    .aeMF       (aeMF),
    .afVC       (afVC),
    .aeVC       (aeVC),
    .afDF       (afDF),
    .aeDF       (aeDF),
    .busy       (busy),
    .done       (done),
    .push_count (push_count),
    .pop_count  (pop_count)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Loads a configuration and pulses start across one rising edge; returns
  // on the falling edge right after that edge.
  task automatic applyStimulus(input logic [CNT_W-1:0] bl, input logic [BURST_W-1:0] nb,
                               input logic [CNT_W-1:0] gl, input logic [DATA_W-1:0] sd,
                               input logic [DATA_W-1:0] st);
    @(negedge clk);
    burst_len  = bl;
    num_bursts = nb;
    gap_len    = gl;
    seed       = sd;
    seed_step  = st;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reset values of every output, with the drain requested while in IDLE
  task automatic test_reset;
    reset_L             = 1'b0;
    start               = 1'b0;
    burst_len           = '0;
    num_bursts          = '0;
    gap_len             = '0;
    seed                = '0;
    seed_step           = '0;
    drain_en            = 1'b1;
    bus.fifo_pause_main = 1'b0;
    bus.fifo_empty      = '0;
    bus.error_in        = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.push_main, bus.data_out, init} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_push_data_init got %0h expected 0", {bus.push_main, bus.data_out, init});
    end
    checks++;
    if ({afMF, aeMF, afVC, aeVC, afDF, aeDF} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_thresholds got %0h expected 0", {afMF, aeMF, afVC, aeVC, afDF, aeDF});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_busy_done got %b expected 00", {busy, done});
    end
    checks++;
    if ({push_count, pop_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_counts got %0h/%0h expected 0/0", push_count, pop_count);
    end
    checks++;
    if (bus.pop !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_pop got %b expected 00", bus.pop);
    end
    reset_L  = 1'b1;
    drain_en = 1'b0;
  endtask

  // Two bursts of 18 words with a one-cycle gap, checking start latency
  task automatic test_main_sequence;
    int idx;
    int gapCyc;
    logic [DATA_W-1:0] expWord;
    $display("[TB] test_main_sequence");
    applyStimulus(8'd18, 4'd2, 8'd1, 6'h2C, 6'h20);
    checks++;
    if ({init, busy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL main_init_pulse got %b expected 11", {init, busy});
    end
    @(negedge clk);
    checks++;
    if (init !== 1'b0) begin
      errors++;
      $display("[TB] FAIL main_init_width got %b expected 0", init);
    end
    checks++;
    if ({afMF, aeMF, afVC, aeVC, afDF, aeDF} !== {2'd3, 2'd1, 4'd14, 4'd2, 2'd3, 2'd1}) begin
      errors++;
      $display("[TB] FAIL main_thresholds got %0h expected %0h",
               {afMF, aeMF, afVC, aeVC, afDF, aeDF}, {2'd3, 2'd1, 4'd14, 4'd2, 2'd3, 2'd1});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.push_main !== 1'b0) begin
        errors++;
        $display("[TB] FAIL main_early_push got %b expected 0", bus.push_main);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.push_main, bus.data_out} !== {1'b1, 6'h2C}) begin
      errors++;
      $display("[TB] FAIL main_first_push got %b/%0h expected 1/2c", bus.push_main, bus.data_out);
    end
    idx    = 1;
    gapCyc = 0;
    for (int cyc = 0; cyc < 80 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.push_main === 1'b1) begin
        expWord = (idx < 18) ? DATA_W'(44 + idx) : DATA_W'(12 + idx - 18);
        checks++;
        if (bus.data_out !== expWord) begin
          errors++;
          $display("[TB] FAIL main_word%0d got %0h expected %0h", idx, bus.data_out, expWord);
        end
        idx++;
      end else if (idx == 18) begin
        gapCyc++;
      end
    end
    checks++;
    if (idx != 36) begin
      errors++;
      $display("[TB] FAIL main_word_total got %0d expected 36", idx);
    end
    checks++;
    if (gapCyc != 1) begin
      errors++;
      $display("[TB] FAIL main_gap_cycles got %0d expected 1", gapCyc);
    end
    checks++;
    if ({done, busy} !== 2'b10 || push_count !== 12'd36) begin
      errors++;
      $display("[TB] FAIL main_done_count got done=%b busy=%b count=%0d expected 1/0/36",
               done, busy, push_count);
    end
    @(negedge clk);
    checks++;
    if ({bus.push_main, done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL main_idle_after_done got %b expected 01", {bus.push_main, done});
    end
  endtask

  // Data wraps modulo 2^DATA_W inside a burst; also restarts from DONE
  task automatic test_wrap;
    int idx;
    logic [DATA_W-1:0] expWord;
    $display("[TB] test_wrap");
    applyStimulus(8'd4, 4'd1, 8'd0, 6'h3E, 6'h00);
    idx = 0;
    for (int cyc = 0; cyc < 40 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.push_main === 1'b1) begin
        expWord = DATA_W'(62 + idx);
        checks++;
        if (bus.data_out !== expWord) begin
          errors++;
          $display("[TB] FAIL wrap_word%0d got %0h expected %0h", idx, bus.data_out, expWord);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 4 || push_count !== 12'd4) begin
      errors++;
      $display("[TB] FAIL wrap_total got %0d/%0d expected 4/4", idx, push_count);
    end
  endtask

  // Three pause cycles mid-burst: exactly three idle cycles, no value skipped
  task automatic test_pause;
    int idx;
    int zeros;
    int left;
    bit pausedOnce;
    logic [DATA_W-1:0] expWord;
    $display("[TB] test_pause");
    applyStimulus(8'd8, 4'd1, 8'd0, 6'h10, 6'h00);
    idx        = 0;
    zeros      = 0;
    left       = 0;
    pausedOnce = 1'b0;
    for (int cyc = 0; cyc < 40 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.push_main === 1'b1) begin
        expWord = DATA_W'(16 + idx);
        checks++;
        if (bus.data_out !== expWord) begin
          errors++;
          $display("[TB] FAIL pause_word%0d got %0h expected %0h", idx, bus.data_out, expWord);
        end
        idx++;
      end else if (idx > 0 && idx < 8) begin
        zeros++;
      end
      if (idx == 3 && !pausedOnce) begin
        bus.fifo_pause_main = 1'b1;
        left                = 3;
        pausedOnce          = 1'b1;
      end else if (left > 0) begin
        left--;
        if (left == 0) bus.fifo_pause_main = 1'b0;
      end
    end
    bus.fifo_pause_main = 1'b0;
    checks++;
    if (idx != 8 || zeros != 3) begin
      errors++;
      $display("[TB] FAIL pause_total_idle got %0d/%0d expected 8/3", idx, zeros);
    end
    checks++;
    if (push_count !== 12'd8) begin
      errors++;
      $display("[TB] FAIL pause_push_count got %0d expected 8", push_count);
    end
  endtask

  // Error for two cycles freezes both pushes and pops, then resumes in order
  task automatic test_error_pop;
    int idx;
    int zeros;
    int left;
    bit errOnce;
    logic [DATA_W-1:0] expWord;
    $display("[TB] test_error_pop");
    drain_en       = 1'b1;
    bus.fifo_empty = 2'b00;
    applyStimulus(8'd8, 4'd1, 8'd0, 6'h20, 6'h00);
    idx     = 0;
    zeros   = 0;
    left    = 0;
    errOnce = 1'b0;
    for (int cyc = 0; cyc < 40 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.push_main === 1'b1) begin
        expWord = DATA_W'(32 + idx);
        checks++;
        if (bus.data_out !== expWord) begin
          errors++;
          $display("[TB] FAIL error_word%0d got %0h expected %0h", idx, bus.data_out, expWord);
        end
        idx++;
      end else if (idx > 0 && idx < 8) begin
        zeros++;
      end
      if (idx == 2 && !errOnce) begin
        bus.error_in = 5'h04;
        left         = 2;
        errOnce      = 1'b1;
        #1;
        checks++;
        if (bus.pop !== 2'b00) begin
          errors++;
          $display("[TB] FAIL error_pop_blocked got %b expected 00", bus.pop);
        end
      end else if (left > 0) begin
        left--;
        if (left == 0) bus.error_in = '0;
        #1;
        checks++;
        if (bus.pop !== ((left == 0) ? 2'b11 : 2'b00)) begin
          errors++;
          $display("[TB] FAIL error_pop_phase%0d got %b expected %b", left, bus.pop,
                   (left == 0) ? 2'b11 : 2'b00);
        end
      end
    end
    bus.error_in = '0;
    drain_en     = 1'b0;
    checks++;
    if (idx != 8 || zeros != 2) begin
      errors++;
      $display("[TB] FAIL error_total_idle got %0d/%0d expected 8/2", idx, zeros);
    end
  endtask

  // burst_len=0 and num_bursts=0 both reach DONE without pushing
  task automatic test_degenerate;
    int pushes;
    bit reachedDone;
    $display("[TB] test_degenerate");
    bus.fifo_empty = 2'b11;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) applyStimulus(8'd0, 4'd2, 8'd0, 6'h07, 6'h01);
      else           applyStimulus(8'd5, 4'd0, 8'd0, 6'h07, 6'h01);
      pushes      = 0;
      reachedDone = 1'b0;
      for (int cyc = 0; cyc < 30 && !reachedDone; cyc++) begin
        @(negedge clk);
        if (bus.push_main === 1'b1) pushes++;
        if (done === 1'b1) reachedDone = 1'b1;
      end
      checks++;
      if (!reachedDone || pushes != 0 || push_count !== '0) begin
        errors++;
        $display("[TB] FAIL degenerate_pass%0d got done=%b pushes=%0d count=%0d expected 1/0/0",
                 pass, reachedDone, pushes, push_count);
      end
    end
  endtask

  // One channel empty: only channel 1 pops, five pops in five cycles
  task automatic test_drain;
    $display("[TB] test_drain");
    checks++;
    if (pop_count !== '0) begin
      errors++;
      $display("[TB] FAIL drain_initial_count got %0d expected 0", pop_count);
    end
    drain_en       = 1'b1;
    bus.fifo_empty = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.pop !== 2'b10) begin
        errors++;
        $display("[TB] FAIL drain_pop%0d got %b expected 10", i, bus.pop);
      end
      @(negedge clk);
    end
    drain_en = 1'b0;
    #1;
    checks++;
    if (pop_count !== 12'd5 || bus.pop !== 2'b00) begin
      errors++;
      $display("[TB] FAIL drain_count got %0d/%b expected 5/00", pop_count, bus.pop);
    end
  endtask

  // The pop total sticks at all-ones instead of wrapping
  task automatic test_saturate;
    $display("[TB] test_saturate");
    drain_en       = 1'b1;
    bus.fifo_empty = 2'b00;
    repeat (2100) @(negedge clk);
    drain_en = 1'b0;
    checks++;
    if (pop_count !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL saturate_pop_count got %0h expected fff", pop_count);
    end
  endtask

  // Reset mid-burst clears everything; a new start re-runs from the seed
  task automatic test_reset_midburst;
    int idx;
    int lat;
    $display("[TB] test_reset_midburst");
    applyStimulus(8'd10, 4'd1, 8'd0, 6'h05, 6'h00);
    idx = 0;
    for (int cyc = 0; cyc < 30 && idx < 3; cyc++) begin
      @(negedge clk);
      if (bus.push_main === 1'b1) idx++;
    end
    checks++;
    if (idx != 3 || push_count !== 12'd3) begin
      errors++;
      $display("[TB] FAIL midburst_progress got %0d/%0d expected 3/3", idx, push_count);
    end
    reset_L        = 1'b0;
    drain_en       = 1'b1;
    bus.fifo_empty = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.push_main, bus.data_out, init, busy, done} !== 10'h000) begin
      errors++;
      $display("[TB] FAIL midburst_reset_outputs got %0h expected 0",
               {bus.push_main, bus.data_out, init, busy, done});
    end
    checks++;
    if ({afMF, aeMF, afVC, aeVC, afDF, aeDF, push_count, pop_count} !== '0 || bus.pop !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midburst_reset_state got thr=%0h push=%0d pop=%0d popv=%b expected 0",
               {afMF, aeMF, afVC, aeVC, afDF, aeDF}, push_count, pop_count, bus.pop);
    end
    reset_L  = 1'b1;
    drain_en = 1'b0;
    applyStimulus(8'd10, 4'd1, 8'd0, 6'h05, 6'h00);
    checks++;
    if (init !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midburst_reinit got %b expected 1", init);
    end
    lat = 0;
    for (int cyc = 0; cyc < 20 && bus.push_main !== 1'b1; cyc++) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.push_main !== 1'b1 || bus.data_out !== 6'h05 || lat != 4) begin
      errors++;
      $display("[TB] FAIL midburst_rerun got push=%b data=%0h lat=%0d expected 1/05/4",
               bus.push_main, bus.data_out, lat);
    end
  endtask

  initial begin
    test_reset();
    test_main_sequence();
    test_wrap();
    test_pause();
    test_error_pop();
    test_degenerate();
    test_drain();
    test_saturate();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
